// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the state encodings, access-size encodings, requester ids and the
// doubleword-crossing helper used when a request is accepted.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // log2(bytes) field of the 3-bit size code; bit 2 is the sign-extend flag
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // Requester ids double as bit positions in the arbiter's request/grant vectors
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  // True when the access would spill past the end of its aligned doubleword.
  // The sum is kept in 4 bits so an 8-byte access at offset 0 gives exactly 8.
  function automatic logic crosses_doubleword(input logic [2:0] offset,
                                              input logic [1:0] log2_bytes);
    logic [3:0] bytes;
    logic [3:0] end_byte;
    case (log2_bytes)
      SIZE_B:  bytes = 4'd1;
      SIZE_H:  bytes = 4'd2;
      SIZE_W:  bytes = 4'd4;
      SIZE_D:  bytes = 4'd8;
      default: bytes = 4'd8;
    endcase
    end_byte = {1'b0, offset} + bytes;
    return end_byte > 4'd8;
  endfunction

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// rr_arbiter_2: two-requester round-robin arbiter.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   req[1:0]    requests, bit REQ_CORE / bit REQ_AUX
//   advance     accept the current grant and move the last-grant pointer
//   grant[1:0]  one-hot grant (combinational), zero when nothing requests
module rr_arbiter_2
  import data_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_aux;

  // A lone requester always wins; on a tie the one not served last wins
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_aux ? 2'b01 : 2'b10;
    end
  end

  // Reset marks aux as last served so the core wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_aux <= 1'b1;
    end else if (advance && (|req)) begin
      last_aux <= grant[REQ_AUX];
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one data-memory port between the core LSU
// ("core") and the debug/loader port ("aux").
// One access in flight, round-robin on ties, doubleword-crossing accesses
// rejected without touching memory, read latency sequenced by a counter.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   core_* / aux_*                   req, we, size, addr, wdata in;
//                                    ready (pulse), err, rdata out
//   mem_read_en, mem_write_en,
//   mem_byte_enable, mem_address,
//   mem_write_data                   registered outputs to the memory interface
//   mem_data_fetched                 read data, sampled at the end of the last WAIT cycle
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [63:0] core_wdata,
  output logic        core_ready,
  output logic        core_err,
  output logic [63:0] core_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [2:0]  aux_size,
  input  logic [31:0] aux_addr,
  input  logic [63:0] aux_wdata,
  output logic        aux_ready,
  output logic        aux_err,
  output logic [63:0] aux_rdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_data_fetched
);

  localparam logic [3:0] LAST_COUNT = 4'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        lat_we_q, lat_we_d;
  logic [2:0]  lat_size_q, lat_size_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [63:0] lat_wdata_q, lat_wdata_d;
  logic        lat_owner_q, lat_owner_d;
  logic        lat_err_q, lat_err_d;
  logic [3:0]  count_q, count_d;
  logic        capture;
  logic [1:0]  grant;
  logic        advance;
  logic        sel_aux;
  logic        active_d;
  logic        respond_d;

  assign advance = (state_q == IDLE);

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({aux_req, core_req}),
    .advance (advance),
    .grant   (grant)
  );

  assign sel_aux = grant[REQ_AUX];

  // Next-state logic; the request fields are latched only when leaving IDLE
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_size_d  = lat_size_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_owner_d = lat_owner_q;
    lat_err_d   = lat_err_q;
    count_d     = count_q;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          lat_owner_d = sel_aux ? REQ_AUX : REQ_CORE;
          lat_we_d    = sel_aux ? aux_we    : core_we;
          lat_size_d  = sel_aux ? aux_size  : core_size;
          lat_addr_d  = sel_aux ? aux_addr  : core_addr;
          lat_wdata_d = sel_aux ? aux_wdata : core_wdata;
          lat_err_d   = crosses_doubleword(lat_addr_d[2:0], lat_size_d[1:0]);
          state_d     = lat_err_d ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        if (lat_we_q) begin
          state_d = RESPOND;
        end else begin
          count_d = 4'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (count_q == LAST_COUNT) begin
          capture = 1'b1;
          state_d = RESPOND;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active_d  = (state_d == ACCESS) || (state_d == WAIT);
  assign respond_d = (state_d == RESPOND);

  // State, latches and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_we_q    <= 1'b0;
      lat_size_q  <= 3'd0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 64'd0;
      lat_owner_q <= REQ_CORE;
      lat_err_q   <= 1'b0;
      count_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_size_q  <= lat_size_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_owner_q <= lat_owner_d;
      lat_err_q   <= lat_err_d;
      count_q     <= count_d;
    end
  end

  // Outputs are registered from the next state so each one lines up with
  // the cycle the FSM is actually in (write pulse in ACCESS, ready in RESPOND)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_en     <= 1'b0;
      mem_write_en    <= 1'b0;
      mem_byte_enable <= 3'd0;
      mem_address     <= 32'd0;
      mem_write_data  <= 64'd0;
      core_ready      <= 1'b0;
      core_err        <= 1'b0;
      core_rdata      <= 64'd0;
      aux_ready       <= 1'b0;
      aux_err         <= 1'b0;
      aux_rdata       <= 64'd0;
    end else begin
      mem_read_en     <= ((state_d == ACCESS) && !lat_we_d) || (state_d == WAIT);
      mem_write_en    <= (state_d == ACCESS) && lat_we_d;
      mem_byte_enable <= active_d ? lat_size_d : 3'd0;
      mem_address     <= active_d ? lat_addr_d : 32'd0;
      mem_write_data  <= ((state_d == ACCESS) && lat_we_d) ? lat_wdata_d : 64'd0;
      core_ready      <= respond_d && (lat_owner_d == REQ_CORE);
      core_err        <= respond_d && (lat_owner_d == REQ_CORE) && lat_err_d;
      aux_ready       <= respond_d && (lat_owner_d == REQ_AUX);
      aux_err         <= respond_d && (lat_owner_d == REQ_AUX) && lat_err_d;
      if (capture && (lat_owner_q == REQ_CORE)) begin
        core_rdata <= mem_data_fetched;
      end
      if (capture && (lat_owner_q == REQ_AUX)) begin
        aux_rdata <= mem_data_fetched;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: a READ_LATENCY=1 instance with a small
// memory model, plus a READ_LATENCY=3 instance for the longer read sequence.
module tb_data_memory_arbiter;

  logic        clk;
  logic        reset;
  logic        core_req, core_we, aux_req, aux_we;
  logic [2:0]  core_size, aux_size;
  logic [31:0] core_addr, aux_addr;
  logic [63:0] core_wdata, aux_wdata;
  logic        core_ready, core_err, aux_ready, aux_err;
  logic [63:0] core_rdata, aux_rdata;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [63:0] mem_write_data, mem_data_fetched;

  logic        core_req_b, core_we_b, aux_req_b, aux_we_b;
  logic [2:0]  core_size_b, aux_size_b;
  logic [31:0] core_addr_b, aux_addr_b;
  logic [63:0] core_wdata_b, aux_wdata_b;
  logic        core_ready_b, core_err_b, aux_ready_b, aux_err_b;
  logic [63:0] core_rdata_b, aux_rdata_b;
  logic        mem_read_en_b, mem_write_en_b;
  logic [2:0]  mem_byte_enable_b;
  logic [31:0] mem_address_b;
  logic [63:0] mem_write_data_b, mem_data_fetched_b;

  int passed = 0;
  int total  = 0;

  data_memory_arbiter #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_size(core_size), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ready(core_ready), .core_err(core_err), .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_size(aux_size), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_ready(aux_ready), .aux_err(aux_err), .aux_rdata(aux_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_data_fetched(mem_data_fetched)
  );

  data_memory_arbiter #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .core_req(core_req_b), .core_we(core_we_b), .core_size(core_size_b), .core_addr(core_addr_b),
    .core_wdata(core_wdata_b), .core_ready(core_ready_b), .core_err(core_err_b), .core_rdata(core_rdata_b),
    .aux_req(aux_req_b), .aux_we(aux_we_b), .aux_size(aux_size_b), .aux_addr(aux_addr_b),
    .aux_wdata(aux_wdata_b), .aux_ready(aux_ready_b), .aux_err(aux_err_b), .aux_rdata(aux_rdata_b),
    .mem_read_en(mem_read_en_b), .mem_write_en(mem_write_en_b), .mem_byte_enable(mem_byte_enable_b),
    .mem_address(mem_address_b), .mem_write_data(mem_write_data_b), .mem_data_fetched(mem_data_fetched_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: doubleword array indexed by address bits [7:3]; read data
  // only becomes valid after read_en has been high for READ_LATENCY edges
  logic [63:0] mem_model [0:31];
  int rd_run, rd_run_b;

  always @(posedge clk) begin
    if (mem_write_en) mem_model[mem_address[7:3]] <= mem_write_data;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_run   <= 0;
      rd_run_b <= 0;
    end else begin
      rd_run   <= mem_read_en   ? rd_run + 1   : 0;
      rd_run_b <= mem_read_en_b ? rd_run_b + 1 : 0;
    end
  end

  assign mem_data_fetched   = (rd_run >= 1) ? mem_model[mem_address[7:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
  assign mem_data_fetched_b = (rd_run_b >= 3) ? {mem_address_b, ~mem_address_b} : 64'hBAD1_BAD1_BAD1_BAD1;

  typedef struct {
    bit          use_aux;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          exp_cycle;
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic [31:0] exp_rd_mask;
    logic [31:0] exp_wr_mask;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive_side(input bit use_aux, input logic req, input logic we,
                            input logic [2:0] size, input logic [31:0] addr, input logic [63:0] wdata);
    if (use_aux) begin
      aux_req = req; aux_we = we; aux_size = size; aux_addr = addr; aux_wdata = wdata;
    end else begin
      core_req = req; core_we = we; core_size = size; core_addr = addr; core_wdata = wdata;
    end
  endtask

  // Runs one transaction on the READ_LATENCY=1 instance and checks timing,
  // result, memory enables, the presented address/size and the idle side
  task automatic apply_stimulus(input vec_t v, input string name);
    logic [31:0] rd_mask, wr_mask, addr1;
    logic [2:0]  be1;
    logic [63:0] got_rdata;
    logic        got_err, my_ready, other_ready;
    int          got_cycle, ready_cnt, other_cnt;
    rd_mask = 0; wr_mask = 0; addr1 = 0; be1 = 0; got_rdata = 0; got_err = 0;
    got_cycle = -1; ready_cnt = 0; other_cnt = 0;
    @(negedge clk);
    drive_side(v.use_aux, 1'b1, v.we, v.size, v.addr, v.wdata);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_read_en)  rd_mask |= (32'd1 << c);
      if (mem_write_en) wr_mask |= (32'd1 << c);
      if (c == 1) begin addr1 = mem_address; be1 = mem_byte_enable; end
      my_ready    = v.use_aux ? aux_ready : core_ready;
      other_ready = v.use_aux ? core_ready : aux_ready;
      if (other_ready) other_cnt++;
      if (my_ready) begin
        ready_cnt++;
        if (got_cycle < 0) begin
          got_cycle = c;
          got_err   = v.use_aux ? aux_err : core_err;
          got_rdata = v.use_aux ? aux_rdata : core_rdata;
        end
        drive_side(v.use_aux, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
      end
      if (got_cycle >= 0 && c >= got_cycle + 2) break;
    end
    drive_side(v.use_aux, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
    check_output({name, " ready_cycle"}, 64'(got_cycle), 64'(v.exp_cycle));
    check_output({name, " err"}, 64'(got_err), 64'(v.exp_err));
    check_output({name, " rdata"}, got_rdata, v.exp_rdata);
    check_output({name, " read_en_cycles"}, 64'(rd_mask), 64'(v.exp_rd_mask));
    check_output({name, " write_en_cycles"}, 64'(wr_mask), 64'(v.exp_wr_mask));
    check_output({name, " ready_pulses"}, 64'(ready_cnt), 64'd1);
    check_output({name, " other_ready"}, 64'(other_cnt), 64'd0);
    if ((v.exp_rd_mask | v.exp_wr_mask) != 0) begin
      check_output({name, " address"}, 64'(addr1), 64'(v.addr));
      check_output({name, " byte_enable"}, 64'(be1), 64'(v.size));
    end
  endtask

  initial begin
    logic [63:0] all_out;
    int          ev_cnt, rdy_cnt, got_cycle;
    int          ev_who[8];
    int          ev_cyc[8];
    logic [31:0] rd_mask;
    logic [63:0] got_rdata;
    vec_t        v;

    //                use_aux we  size    addr          wdata                  cyc err rdata                  rd     wr
    vecs[0] = '{0, 1'b1, 3'b011, 32'h0000_2010, 64'h1122334455667788, 2, 1'b0, 64'h0,                32'h0, 32'h2};
    vecs[1] = '{0, 1'b0, 3'b011, 32'h0000_2010, 64'h0,                3, 1'b0, 64'h1122334455667788, 32'h6, 32'h0};
    vecs[2] = '{0, 1'b1, 3'b011, 32'h0000_2010, 64'h80000000_12345678, 2, 1'b0, 64'h1122334455667788, 32'h0, 32'h2};
    vecs[3] = '{0, 1'b0, 3'b110, 32'h0000_2014, 64'h0,                3, 1'b0, 64'h80000000_12345678, 32'h6, 32'h0};
    vecs[4] = '{0, 1'b0, 3'b010, 32'h0000_2006, 64'h0,                1, 1'b1, 64'h80000000_12345678, 32'h0, 32'h0};
    vecs[5] = '{0, 1'b1, 3'b001, 32'h0000_2007, 64'h5555,             1, 1'b1, 64'h80000000_12345678, 32'h0, 32'h0};
    vecs[6] = '{0, 1'b1, 3'b000, 32'h0000_2007, 64'hAB,               2, 1'b0, 64'h80000000_12345678, 32'h0, 32'h2};
    vecs[7] = '{0, 1'b0, 3'b011, 32'h0000_2011, 64'h0,                1, 1'b1, 64'h80000000_12345678, 32'h0, 32'h0};
    vecs[8] = '{1, 1'b0, 3'b010, 32'h0000_2006, 64'h0,                1, 1'b1, 64'h0,                32'h0, 32'h0};
    vecs[9] = '{1, 1'b0, 3'b010, 32'h0000_2004, 64'h0,                3, 1'b0, 64'hAB,               32'h6, 32'h0};

    reset = 1'b1;
    drive_side(0, 1'b1, 1'b1, 3'b011, 32'h0000_2000, 64'h1111);
    drive_side(1, 1'b1, 1'b1, 3'b011, 32'h0000_2008, 64'h2222);
    core_req_b = 0; core_we_b = 0; core_size_b = 0; core_addr_b = 0; core_wdata_b = 0;
    aux_req_b = 0; aux_we_b = 0; aux_size_b = 0; aux_addr_b = 0; aux_wdata_b = 0;
    #1;
    all_out = {core_ready, core_err, aux_ready, aux_err, mem_read_en, mem_write_en, mem_byte_enable}
              | 64'(core_rdata) | 64'(aux_rdata) | 64'(mem_address) | mem_write_data;
    check_output("reset_outputs_zero", all_out, 64'h0);

    // Both requesters held high from reset: grants must alternate core, aux
    ev_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (core_ready && ev_cnt < 8) begin ev_who[ev_cnt] = 0; ev_cyc[ev_cnt] = c; ev_cnt++; end
      if (aux_ready && ev_cnt < 8)  begin ev_who[ev_cnt] = 1; ev_cyc[ev_cnt] = c; ev_cnt++; end
      if (ev_cnt >= 4) begin
        drive_side(0, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
        drive_side(1, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
      end
    end
    check_output("rr_ready_count", 64'(ev_cnt), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ev_cnt) begin
        check_output($sformatf("rr_grant_%0d_owner", k), 64'(ev_who[k]), 64'(k % 2));
        check_output($sformatf("rr_grant_%0d_cycle", k), 64'(ev_cyc[k]), 64'(2 + 3 * k));
      end else begin
        check_output($sformatf("rr_grant_%0d_missing", k), 64'(ev_cnt), 64'(k + 1));
      end
    end

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulsed during WAIT of a core load
    @(negedge clk);
    drive_side(0, 1'b1, 1'b0, 3'b011, 32'h0000_2010, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check_output("midreset_in_wait_read_en", 64'(mem_read_en), 64'd1);
    reset = 1'b1;
    drive_side(0, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
    #1;
    all_out = {core_ready, core_err, aux_ready, aux_err, mem_read_en, mem_write_en, mem_byte_enable}
              | 64'(core_rdata) | 64'(aux_rdata) | 64'(mem_address) | mem_write_data;
    check_output("midreset_outputs_zero", all_out, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    rdy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (core_ready) rdy_cnt++;
    end
    check_output("midreset_no_ready", 64'(rdy_cnt), 64'd0);
    v = '{0, 1'b0, 3'b011, 32'h0000_2010, 64'h0, 3, 1'b0, 64'h80000000_12345678, 32'h6, 32'h0};
    apply_stimulus(v, "after_reset_load");

    // READ_LATENCY=3 instance: core load
    rd_mask = 0; got_cycle = -1; got_rdata = 0; rdy_cnt = 0;
    @(negedge clk);
    core_req_b = 1'b1; core_we_b = 1'b0; core_size_b = 3'b011; core_addr_b = 32'h0000_2010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_read_en_b) rd_mask |= (32'd1 << c);
      if (core_ready_b) begin
        rdy_cnt++;
        if (got_cycle < 0) begin got_cycle = c; got_rdata = core_rdata_b; end
        core_req_b = 1'b0;
      end
    end
    core_req_b = 1'b0;
    check_output("lat3 ready_cycle", 64'(got_cycle), 64'd5);
    check_output("lat3 read_en_cycles", 64'(rd_mask), 64'h1E);
    check_output("lat3 rdata", got_rdata, {32'h0000_2010, 32'hFFFF_DFEF});
    check_output("lat3 ready_pulses", 64'(rdy_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
